team_06_i2s_rx_stereo: RTL and testbench
========================================

TEAM_06_I2S_RX_STEREO -- requirements
Module: team_06_i2s_rx_stereo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, sample bits captured per slot (1..SLOT_W-1).
REQ-002 SHALL have parameter SLOT_W, default 32, sck periods per channel slot (>=2).
REQ-003 SHALL have parameter DIV, default 4, clk cycles per sck half-period (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output word buffer depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  run enable; low stops the serial interface.
REQ-008 SHALL have port sd_in  input  1  serial data from ADC, synchronous to clk, MSB first.
REQ-009 SHALL have port sck  output  1  generated bit clock to ADC.
REQ-010 SHALL have port ws  output  1  word select; 0 = left slot, 1 = right slot.
REQ-011 SHALL have port sample_out  output  SAMPLE_W  head-of-FIFO sample, raw two's complement.
REQ-012 SHALL have port sample_ch  output  1  channel of sample_out (0 left, 1 right).
REQ-013 SHALL have port sample_valid  output  1  FIFO not empty.
REQ-014 SHALL have port sample_ready  input  1  consumer accepts head word when valid&ready.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse when a completed word is dropped.
REQ-016 SHALL have port overflow_sticky  output  1  latched overflow, cleared by rst or en low.

Function
REQ-017 Divider: div_cnt counts 0..DIV-1 while en; at DIV-1 sck toggles, div_cnt -> 0; rise event = toggle from 0, fall event = toggle from 1.
REQ-018 Slot position pos (0..SLOT_W-1) SHALL increment on each fall event; on wrap SLOT_W-1 -> 0 ws SHALL toggle in the same cycle.
REQ-019 On rise event at pos 0 sd_in SHALL be ignored (previous word LSB); at pos 1..SAMPLE_W sd_in SHALL shift in MSB first; pos > SAMPLE_W ignored.
REQ-020 Captured word SHALL be tagged with ws value during its slot.
REQ-021 Final bit sampled at clk edge N SHALL be written to the FIFO at edge N+1; if FIFO was empty, sample_valid high after edge N+1.
REQ-022 FIFO SHALL be first-word-fall-through; pop on sample_valid & sample_ready; order preserved across channels.
REQ-023 Write while full and no pop SHALL drop the new word, pulse overflow one cycle, set overflow_sticky; FIFO contents unchanged.
REQ-024 Write and pop in the same cycle while full SHALL both succeed, no overflow.
REQ-025 Pop while empty SHALL have no effect; sample_out/sample_ch hold last value.
REQ-026 en low SHALL on the next edge force sck=0, ws=0, div_cnt=0, pos=0, discard partial word, clear overflow_sticky; FIFO retained and drainable.
REQ-027 en rising SHALL start a left slot at pos 0 with sck low for DIV cycles.

Reset
REQ-028 rst SHALL set sck=0, ws=0, sample_out=0, sample_ch=0, sample_valid=0, overflow=0, overflow_sticky=0, counters and FIFO empty; rst overrides en and all activity, including mid-word.

Structure
REQ-029 Package team_06_i2s_pkg SHALL hold default parameter constants and channel typedef (CH_LEFT=0, CH_RIGHT=1).
REQ-030 FIFO SHALL be a sub-module team_06_sync_fifo (parametrised width SAMPLE_W+1, depth FIFO_DEPTH, full/empty flags).

Verification (SAMPLE_W=8, SLOT_W=16, DIV=2, FIFO_DEPTH=4)
REQ-031 Reset: rst high 3 cycles -> all outputs 0; after release with en=1, sck first rises after 2 clk, period 4 clk.
REQ-032 Stereo: drive left 0xA7, right 0x5A at pos 1..8, ready=1 -> words (0xA7,ch0) then (0x5A,ch1); ws toggles every 64 clk.
REQ-033 Truncation: pos 0 and pos 9..15 driven 1, pos 1..8 driven 0 -> word 0x00.
REQ-034 Overflow: ready=0 over 6 slots of 0x01..0x06 -> overflow pulses twice, sticky=1, drain yields 0x01..0x04; simultaneous write/pop when full -> no pulse.
REQ-035 Enable drop: en low after 3 bits of a word -> no word written, sck=ws=0 next cycle, sticky cleared; re-enable -> next left word 0x3C captured correctly.
REQ-036 Reset mid-word with 2 words buffered -> valid=0, FIFO empty, no partial word emitted afterward.

Source files
------------

// File: rtl/team_06_i2s_pkg.sv
// Shared defaults and channel encoding for the stereo I2S receiver.
package team_06_i2s_pkg;

  localparam int unsigned SAMPLE_W_DEF   = 8;
  localparam int unsigned SLOT_W_DEF     = 32;
  localparam int unsigned DIV_DEF        = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

endpackage

// File: rtl/team_06_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
module team_06_sync_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          pop, push;

  // Pointer, occupancy and head-word next state; head holds when the FIFO drains.
  always_comb begin
    pop      = rd_en & ~empty_q;
    push     = wr_en & (~full_q | pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    head_d   = head_q;
    if (cnt_d != '0) begin
      if (push && ((cnt_q - CW'(pop)) == '0)) head_d = wr_data;
      else                                    head_d = mem_q[rd_ptr_d];
    end
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = head_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/team_06_i2s_rx_stereo.sv
// I2S stereo receiver master: generates sck/ws, captures MSB-first words into a FIFO.
module team_06_i2s_rx_stereo
  import team_06_i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
  parameter int unsigned SLOT_W     = SLOT_W_DEF,
  parameter int unsigned DIV        = DIV_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sd_in,
  output logic                sck,
  output logic                ws,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_ch,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic                overflow_sticky
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned POS_W  = $clog2(SLOT_W);
  localparam int unsigned WORD_W = SAMPLE_W + 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                sck_q, sck_d;
  ch_e                 ws_q, ws_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                wdone_q, wdone_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                ovf_q, ovf_d;
  logic                sticky_q, sticky_d;
  logic                tick;
  logic                fifo_full, fifo_empty;
  logic                pop_c, drop_c;
  logic [WORD_W-1:0]   fifo_rd;

  // Bit-clock divider, slot position and shift capture.
  always_comb begin
    div_d   = div_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    pos_d   = pos_q;
    shift_d = shift_q;
    wdone_d = 1'b0;
    wdata_d = wdata_q;
    tick    = (div_q == DIV_W'(DIV - 1));
    if (!en) begin
      div_d   = '0;
      sck_d   = 1'b0;
      ws_d    = CH_LEFT;
      pos_d   = '0;
      shift_d = '0;
    end else if (!tick) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      sck_d = ~sck_q;
      if (sck_q) begin
        // Falling sck advances the slot position; wrap flips the channel.
        if (pos_q == POS_W'(SLOT_W - 1)) begin
          pos_d = '0;
          ws_d  = (ws_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else if ((pos_q != '0) && (pos_q <= POS_W'(SAMPLE_W))) begin
        // Rising sck samples data bits; position 0 carries the previous LSB.
        shift_d = SAMPLE_W'({shift_q, sd_in});
        if (pos_q == POS_W'(SAMPLE_W)) begin
          wdone_d = 1'b1;
          wdata_d = {1'(ws_q), shift_d};
        end
      end
    end
  end

  // Overflow detection mirrors the FIFO acceptance rule.
  always_comb begin
    pop_c    = sample_ready & ~fifo_empty;
    drop_c   = wdone_q & fifo_full & ~pop_c;
    ovf_d    = drop_c;
    sticky_d = en ? (sticky_q | drop_c) : 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      sck_q    <= 1'b0;
      ws_q     <= CH_LEFT;
      pos_q    <= '0;
      shift_q  <= '0;
      wdone_q  <= 1'b0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      sck_q    <= sck_d;
      ws_q     <= ws_d;
      pos_q    <= pos_d;
      shift_q  <= shift_d;
      wdone_q  <= wdone_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  team_06_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wdone_q),
    .wr_data (wdata_q),
    .rd_en   (sample_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sck             = sck_q;
  assign ws              = ws_q;
  assign sample_out      = fifo_rd[SAMPLE_W-1:0];
  assign sample_ch       = fifo_rd[SAMPLE_W];
  assign sample_valid    = ~fifo_empty;
  assign overflow        = ovf_q;
  assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_team_06_i2s_rx_stereo.sv
// Randomized bench for the stereo I2S receiver with a timing/queue reference model.
module tb_team_06_i2s_rx_stereo;

  localparam int unsigned SW = 8;
  localparam int unsigned SL = 16;
  localparam int unsigned DV = 2;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sd_in = 1'b0;
  logic          sample_ready = 1'b0;
  logic          sck, ws, sample_ch, sample_valid, overflow, overflow_sticky;
  logic [SW-1:0] sample_out;

  always #5 clk = ~clk;

  team_06_i2s_rx_stereo #(
    .SAMPLE_W   (SW),
    .SLOT_W     (SL),
    .DIV        (DV),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .sd_in           (sd_in),
    .sck             (sck),
    .ws              (ws),
    .sample_out      (sample_out),
    .sample_ch       (sample_ch),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since enable, slot words, pending write, output queue.
  int            k = 0;
  logic [SW-1:0] words [16];
  logic          pend = 1'b0;
  logic [SW:0]   pend_w = '0;
  logic [SW:0]   q [$];
  logic [SW-1:0] last_out = '0;
  logic          last_ch = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_sticky = 1'b0;
  int            fill_ones = 0;
  int            dut_ovf = 0;
  logic [SW:0]   popped [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int i);
    if (popped.size() > i) return 32'(popped[i]);
    return 32'hDEAD;
  endfunction

  // One clock: drive inputs, advance the model for this edge, then compare.
  task automatic step(input logic r, input logic e, input logic rdy);
    int   m, slot, pos, mm;
    logic pop, drop;
    rst          = r;
    en           = e;
    sample_ready = rdy;
    m    = k / int'(2 * DV);
    slot = m / int'(SL);
    pos  = m % int'(SL);
    if (pos >= 1 && pos <= int'(SW)) sd_in = words[slot % 16][int'(SW) - pos];
    else                             sd_in = (fill_ones != 0) ? 1'b1 : 1'($urandom);
    if (!r && rdy && sample_valid) popped.push_back({sample_ch, sample_out});
    @(posedge clk);
    if (r) begin
      k = 0; pend = 1'b0; q.delete();
      last_out = '0; last_ch = 1'b0; exp_ovf = 1'b0; exp_sticky = 1'b0;
    end else begin
      pop  = rdy && (q.size() > 0);
      drop = 1'b0;
      if (pend) begin
        if (!pop && q.size() == int'(FD)) drop = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (pend && !drop) q.push_back(pend_w);
      exp_ovf = drop;
      if (!e)        exp_sticky = 1'b0;
      else if (drop) exp_sticky = 1'b1;
      pend = 1'b0;
      if (e) begin
        k++;
        if (k >= int'(DV) && ((k - int'(DV)) % int'(2 * DV)) == 0) begin
          mm = (k - int'(DV)) / int'(2 * DV);
          if ((mm % int'(SL)) == int'(SW)) begin
            pend   = 1'b1;
            pend_w = {1'((mm / int'(SL)) % 2), words[(mm / int'(SL)) % 16]};
          end
        end
      end else begin
        k = 0;
      end
      if (q.size() > 0) begin
        last_out = q[0][SW-1:0];
        last_ch  = q[0][SW];
      end
    end
    #1;
    if (overflow) dut_ovf++;
    chk("sck",          32'(sck),             32'((k / int'(DV)) % 2));
    chk("ws",           32'(ws),              32'((k / int'(2 * DV * SL)) % 2));
    chk("sample_valid", 32'(sample_valid),    32'(q.size() > 0));
    chk("sample_out",   32'(sample_out),      32'(last_out));
    chk("sample_ch",    32'(sample_ch),       32'(last_ch));
    chk("overflow",     32'(overflow),        32'(exp_ovf));
    chk("sticky",       32'(overflow_sticky), 32'(exp_sticky));
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) words[i] = SW'($urandom);
  endtask

  int ovf_base;

  initial begin
    rand_words();

    // Reset for three cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

    // Stereo capture: left 0xA7, right 0x5A.
    rand_words();
    words[0] = 8'hA7; words[1] = 8'h5A;
    popped.delete();
    for (int i = 0; i < 138; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("stereo_cnt", 32'(popped.size()), 32'd2);
    chk("stereo_w0",  pk(0), 32'h0A7);
    chk("stereo_w1",  pk(1), 32'h15A);

    // Truncation: non-data positions driven high, data bits low.
    words[0] = 8'h00; fill_ones = 1;
    popped.delete();
    for (int i = 0; i < 66; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    fill_ones = 0;
    chk("trunc_w0", pk(0), 32'h000);

    // Overflow over six slots, then drop enable three bits into the next left word.
    rand_words();
    for (int i = 0; i < 6; i++) words[i] = SW'(i + 1);
    ovf_base = dut_ovf;
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b0);
    chk("ovf_pulses", 32'(dut_ovf - ovf_base), 32'd2);
    chk("ovf_sticky_set", 32'(overflow_sticky), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("endrop_sticky", 32'(overflow_sticky), 32'd0);
    chk("endrop_sck",    32'(sck), 32'd0);
    chk("endrop_ws",     32'(ws), 32'd0);
    popped.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    chk("drain_cnt", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("drain_w", pk(i), 32'({1'(i % 2), SW'(i + 1)}));

    // Re-enable: next left word 0x3C.
    rand_words();
    words[0] = 8'h3C;
    popped.delete();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("reen_cnt", 32'(popped.size()), 32'd1);
    chk("reen_w0",  pk(0), 32'h03C);

    // Simultaneous write and pop while full.
    rand_words();
    for (int i = 0; i < 5; i++) words[i] = SW'(i + 1);
    popped.delete();
    ovf_base = dut_ovf;
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'(k == 290));
    chk("wrpop_no_ovf", 32'(dut_ovf - ovf_base), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    chk("wrpop_cnt", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("wrpop_w", pk(i), 32'({1'(i % 2), SW'(i + 1)}));

    // Randomized traffic with random ready.
    rand_words();
    for (int i = 0; i < 560; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

    // Reset mid-word with two words buffered.
    rand_words();
    for (int i = 0; i < 140; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(sample_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    popped.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
    chk("rst_no_partial", 32'(popped.size()), 32'd0);
    chk("rst_valid_after", 32'(sample_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
